// File: rtl/stream_mux4to1_pkg.sv
// Shared definitions for the 4-to-1 packet stream multiplexer.
//   NUM_CH  : number of input channels
//   SEL_W   : width of a channel index
//   state_t : packet-lock FSM states
package stream_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/stream_mux4to1_if.sv
// Handshake bundle between four stream producers, the multiplexer and one
// consumer.
//   in_data/in_valid/in_last : per-channel beats from the producers
//   in_ready                 : per-channel accept from the multiplexer
//   out_data/out_last/out_sel/out_valid : merged beat toward the consumer
//   out_ready                : consumer accept
// Modports: master = producers + consumer side (the environment),
//           slave  = the multiplexer itself.
interface stream_mux4to1_if
  import stream_pkg::*;
#(
  parameter int DATA_W = 8
);

  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_last;
  logic [NUM_CH-1:0]        in_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_last;
  logic [SEL_W-1:0]         out_sel;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_last, out_sel, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_last, out_sel, out_valid
  );

endinterface

// File: rtl/stream_mux4to1_rr_arbiter4.sv
// Combinational four-way round-robin arbiter.
//   req        : request per channel
//   last_grant : channel granted most recently; search starts one above it
//   grant      : one-hot grant, zero when nothing requests
//   grant_idx  : index of the granted channel (0 when nothing requests)
module rr_arbiter4
  import stream_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  last_grant,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx
);

  logic [SEL_W-1:0] idx;
  logic             found;

  // The index addition wraps naturally in SEL_W bits, giving the rotation.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = last_grant + SEL_W'(k);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/stream_mux4to1.sv
// Four-input packet stream multiplexer with round-robin arbitration and
// packet lock; a single registered output stage.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : handshake bundle (slave view); see stream_mux4to1_if
module stream_mux4to1
  import stream_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input logic             clk,
  input logic             rst_n,
  stream_mux4to1_if.slave bus
);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  lock_ch_q, lock_ch_d;
  logic [SEL_W-1:0]  last_grant_q, last_grant_d;
  logic [NUM_CH-1:0] arb_grant;
  logic [SEL_W-1:0]  arb_idx;
  logic [NUM_CH-1:0] grant;
  logic [SEL_W-1:0]  grant_idx;
  logic [NUM_CH-1:0] ready;
  logic              load;
  logic              xfer;
  logic [DATA_W-1:0] sel_data;
  logic              sel_last;

  logic [DATA_W-1:0] data_p0;
  logic              last_p0;
  logic [SEL_W-1:0]  sel_p0;
  logic              vld_p0;

  rr_arbiter4 u_arb (
    .req        (bus.in_valid),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .grant_idx  (arb_idx)
  );

  assign load = ~vld_p0 | bus.out_ready;

  always_comb begin
    state_d      = state_q;
    lock_ch_d    = lock_ch_q;
    last_grant_d = last_grant_q;
    if (state_q == ST_LOCKED) begin
      grant     = NUM_CH'(1) << lock_ch_q;
      grant_idx = lock_ch_q;
    end else begin
      grant     = arb_grant;
      grant_idx = arb_idx;
    end
    // Beats offered while reset is held would be lost, so refuse them.
    ready    = (load && rst_n) ? grant : '0;
    xfer     = |(ready & bus.in_valid);
    sel_data = bus.in_data[grant_idx*DATA_W +: DATA_W];
    sel_last = bus.in_last[grant_idx];
    if (xfer) begin
      last_grant_d = grant_idx;
      if (state_q == ST_IDLE && !sel_last) begin
        state_d   = ST_LOCKED;
        lock_ch_d = grant_idx;
      end else if (state_q == ST_LOCKED && sel_last) begin
        state_d = ST_IDLE;
      end
    end
  end

  // Stage p0: output register and lock FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      lock_ch_q    <= '0;
      last_grant_q <= SEL_W'(NUM_CH - 1);
      vld_p0       <= 1'b0;
      data_p0      <= '0;
      last_p0      <= 1'b0;
      sel_p0       <= '0;
    end else begin
      state_q      <= state_d;
      lock_ch_q    <= lock_ch_d;
      last_grant_q <= last_grant_d;
      if (load) begin
        vld_p0 <= xfer;
        if (xfer) begin
          data_p0 <= sel_data;
          last_p0 <= sel_last;
          sel_p0  <= grant_idx;
        end
      end
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_data  = data_p0;
  assign bus.out_last  = last_p0;
  assign bus.out_sel   = sel_p0;
  assign bus.out_valid = vld_p0;

endmodule

// File: tb/tb_stream_mux4to1.sv
module tb_stream_mux4to1;
  import stream_pkg::*;

  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  stream_mux4to1_if #(.DATA_W(DATA_W)) bus ();

  stream_mux4to1 #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: output register contents, owning channel of an open
  // packet (-1 when none) and the most recently served channel.
  bit   m_vld;
  int   m_data, m_last, m_sel;
  int   m_owner;
  int   m_lastg;

  typedef struct {int ch; int d; int l; int cyc;} beat_t;
  beat_t sb[$];    // beats accepted and not yet delivered
  beat_t olog[$];  // delivered beats
  int    last_xfer_ch;

  task automatic model_reset();
    m_vld = 0; m_data = 0; m_last = 0; m_sel = 0;
    m_owner = -1; m_lastg = 3;
    sb.delete();
  endtask

  function automatic int model_grant();
    if (!rst_n) return -1;
    if (m_vld && !bus.out_ready) return -1;
    if (m_owner >= 0) return m_owner;
    for (int k = 1; k <= 4; k++) begin
      if (bus.in_valid[(m_lastg + k) % 4]) return (m_lastg + k) % 4;
    end
    return -1;
  endfunction

  // Called at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic step();
    int g, d, l;
    bit xf;
    beat_t b;
    #3;
    g = model_grant();
    check_val("in_ready", {28'd0, bus.in_ready}, (g >= 0) ? (32'd1 << g) : 32'd0);
    check_val("out_valid", {31'd0, bus.out_valid}, {31'd0, m_vld});
    if (m_vld) begin
      check_val("out_data", {24'd0, bus.out_data}, m_data);
      check_val("out_last", {31'd0, bus.out_last}, m_last);
      check_val("out_sel", {30'd0, bus.out_sel}, m_sel);
    end
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check_val("sb_unexpected_beat", 1, 0);
      end else begin
        b = sb.pop_front();
        check_val("sb_data", {24'd0, bus.out_data}, b.d);
        check_val("sb_sel", {30'd0, bus.out_sel}, b.ch);
        check_val("sb_last", {31'd0, bus.out_last}, b.l);
      end
      olog.push_back('{ch: int'(bus.out_sel), d: int'(bus.out_data),
                       l: int'(bus.out_last), cyc: cyc});
    end
    xf = (g >= 0) && bus.in_valid[g];
    d = 0; l = 0;
    if (xf) begin
      d = int'(bus.in_data[g*DATA_W +: DATA_W]);
      l = int'(bus.in_last[g]);
    end
    last_xfer_ch = xf ? g : -1;
    @(posedge clk);
    if (!m_vld || bus.out_ready) begin
      m_vld = xf;
      if (xf) begin
        m_data = d; m_last = l; m_sel = g;
        sb.push_back('{ch: g, d: d, l: l, cyc: cyc});
      end
    end
    if (xf) begin
      m_lastg = g;
      if (m_owner < 0 && l == 0) m_owner = g;
      else if (m_owner >= 0 && l == 1) m_owner = -1;
    end
    cyc++;
    #1;
  endtask

  // Asserts reset mid-cycle with whatever inputs are active; returns at posedge+1.
  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_out_valid", {31'd0, bus.out_valid}, 0);
    check_val("rst_out_data", {24'd0, bus.out_data}, 0);
    check_val("rst_in_ready", {28'd0, bus.in_ready}, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d);
    bus.in_valid = v;
    bus.in_last  = l;
    bus.in_data  = d;
  endtask

  initial begin
    beat_t b;
    logic [7:0] hold_d;
    logic [7:0] c3;
    drive(4'b0000, 4'b0000, 32'd0);
    bus.out_ready = 1'b1;
    model_reset();
    @(posedge clk);
    #1;

    // Round robin with all channels busy, reset applied with inputs active.
    drive(4'b1111, 4'b1111, 32'hA3A2A1A0);
    apply_reset();
    olog.delete();
    repeat (6) step();
    check_val("rr_count", olog.size(), 5);
    for (int i = 0; i < 5 && i < olog.size(); i++) begin
      check_val($sformatf("rr_data%0d", i), olog[i].d, 32'hA0 + (i % 4));
      check_val($sformatf("rr_sel%0d", i), olog[i].ch, i % 4);
    end
    drive(4'b0000, 4'b0000, 32'd0);
    repeat (2) step();

    // Packet lock: ch1 three beats with a 2-cycle gap, ch2 waiting.
    apply_reset();
    olog.delete();
    drive(4'b0110, 4'b0100, 32'h00_22_11_00); step();
    drive(4'b0110, 4'b0100, 32'h00_22_12_00); step();
    drive(4'b0100, 4'b0100, 32'h00_22_12_00); step();
    check_val("lock_gap_rdy2", {31'd0, bus.in_ready[2]}, 0);
    step();
    drive(4'b0110, 4'b0110, 32'h00_22_13_00); step();
    drive(4'b0100, 4'b0100, 32'h00_22_00_00); step();
    drive(4'b0000, 4'b0000, 32'd0);
    repeat (3) step();
    check_val("lock_count", olog.size(), 4);
    if (olog.size() == 4) begin
      check_val("lock_b0", olog[0].d, 32'h11);
      check_val("lock_b1", olog[1].d, 32'h12);
      check_val("lock_b2", olog[2].d, 32'h13);
      check_val("lock_b3", olog[3].d, 32'h22);
      check_val("lock_sel", olog[0].ch + olog[1].ch + olog[2].ch, 3);
      check_val("lock_sel3", olog[3].ch, 2);
      check_val("lock_back2back", olog[3].cyc - olog[2].cyc, 1);
    end

    // Backpressure on a ch3 stream.
    apply_reset();
    c3 = 8'h30;
    drive(4'b1000, 4'b1000, {c3, 24'd0});
    repeat (2) begin
      step();
      if (last_xfer_ch == 3) c3++;
      drive(4'b1000, 4'b1000, {c3, 24'd0});
    end
    bus.out_ready = 1'b0;
    hold_d = bus.out_data;
    repeat (4) begin
      step();
      check_val("bp_hold_data", {24'd0, bus.out_data}, {24'd0, hold_d});
      check_val("bp_no_ready", {28'd0, bus.in_ready}, 0);
      if (last_xfer_ch == 3) c3++;
    end
    bus.out_ready = 1'b1;
    repeat (4) begin
      step();
      if (last_xfer_ch == 3) c3++;
      drive(4'b1000, 4'b1000, {c3, 24'd0});
    end
    drive(4'b0000, 4'b0000, 32'd0);
    repeat (2) step();
    check_val("bp_sb_empty", sb.size(), 0);

    // Idle and bubble, then ch3 wins after ch2.
    apply_reset();
    drive(4'b0100, 4'b0100, 32'h00_5C_00_00); step();
    drive(4'b0000, 4'b0000, 32'd0);
    #3;
    check_val("bub_vld1", {31'd0, bus.out_valid}, 1);
    check_val("bub_sel", {30'd0, bus.out_sel}, 2);
    check_val("bub_data", {24'd0, bus.out_data}, 32'h5C);
    #2 @(posedge clk); #1; cyc++;
    m_vld = 0; sb.delete();
    #3;
    check_val("bub_vld0", {31'd0, bus.out_valid}, 0);
    #2 @(posedge clk); #1; cyc++;
    drive(4'b1100, 4'b1100, 32'h33_22_00_00);
    #3;
    check_val("bub_ch3_wins", {28'd0, bus.in_ready}, 32'b1000);
    #2 @(posedge clk); #1; cyc++;
    drive(4'b0000, 4'b0000, 32'd0);

    // Reset mid-packet: ch0 opens a packet, reset drops it.
    apply_reset();
    drive(4'b0001, 4'b0000, 32'h00_00_00_77); step();
    drive(4'b0000, 4'b0000, 32'd0); step();
    apply_reset();
    drive(4'b0010, 4'b0010, 32'h00_00_88_00);
    #3;
    check_val("rstpkt_ch1_rdy", {28'd0, bus.in_ready}, 32'b0010);
    #2 @(posedge clk); #1; cyc++;
    drive(4'b0000, 4'b0000, 32'd0);

    // Randomised traffic against the model.
    apply_reset();
    for (int n = 0; n < 3000; n++) begin
      drive(4'($urandom), 4'($urandom_range(0, 15) & $urandom_range(0, 15)), $urandom);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    bus.out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      drive(4'b1111, 4'b1111, $urandom);
      if (m_owner < 0) drive(4'b0000, 4'b0000, 32'd0);
      step();
    end
    drive(4'b0000, 4'b0000, 32'd0);
    repeat (3) step();
    check_val("rand_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
